// File: rtl/mcash_ch_req_driver_if.sv
// Request/return channel between a request driver (master) and an mcash channel port (slave).
interface mcash_ch_req_driver_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 64
);
    logic              req_valid;
    logic [ADDR_W-1:0] req_addr;
    logic              req_allowIn;
    logic              rtn_valid;
    logic [DATA_W-1:0] rtn_data;

    modport master (
        output req_valid,
        output req_addr,
        input  req_allowIn,
        input  rtn_valid,
        input  rtn_data
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        output req_allowIn,
        output rtn_valid,
        output rtn_data
    );
endinterface

// File: rtl/mcash_ch_req_driver.sv
// Burst read initiator for one mcash request channel with outstanding-read credit limit.
// Define MCASH_REQ_DRV_RAND_GAP_EN to insert LFSR-driven idle gaps between requests.
module mcash_ch_req_driver #(
    parameter int unsigned ADDR_W          = 32,
    parameter int unsigned DATA_W          = 64,
    parameter int unsigned CNT_W           = 10,
    parameter int unsigned MAX_OUTSTANDING = 16,
    parameter int unsigned ADDR_STRIDE     = 64,
    localparam int unsigned OUT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         start_i,
    input  logic [ADDR_W-1:0]            base_addr_i,
    input  logic [CNT_W-1:0]             num_req_i,
    mcash_ch_req_driver_if.master        bus,
    output logic [OUT_W-1:0]             outstanding_o,
    output logic [CNT_W-1:0]             rtn_cnt_o,
    output logic                         busy_o,
    output logic                         done_o,
    output logic                         err_o
);

    typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

    localparam logic [OUT_W-1:0]  MaxOut = OUT_W'(MAX_OUTSTANDING);
    localparam logic [ADDR_W-1:0] Stride = ADDR_W'(ADDR_STRIDE);

    state_e            state_q, state_d;
    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  remaining_q, remaining_d;
    logic [OUT_W-1:0]  outstanding_q, outstanding_d;
    logic [CNT_W-1:0]  rtn_cnt_q, rtn_cnt_d;
    logic              err_q, err_d;

    logic kickoff, rtn_ok, credit;

    // Return data is consumed by the channel checker elsewhere; only the count matters here.
    logic [DATA_W-1:0] unused_rtn_data;
    assign unused_rtn_data = bus.rtn_data;

`ifdef MCASH_REQ_DRV_RAND_GAP_EN
    logic [15:0] lfsr_q, lfsr_d;
    logic [1:0]  gap_q, gap_d;

    assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
`endif

    assign kickoff = valid_q & bus.req_allowIn;
    assign rtn_ok  = bus.rtn_valid & (outstanding_q != '0);

    always_comb begin
        outstanding_d = outstanding_q;
        unique case ({kickoff, rtn_ok})
            2'b10:   outstanding_d = outstanding_q + OUT_W'(1);
            2'b01:   outstanding_d = outstanding_q - OUT_W'(1);
            default: outstanding_d = outstanding_q;
        endcase
    end

    // Credit looks at next-cycle occupancy so a valid raised now never exceeds the cap.
    assign credit = (outstanding_d < MaxOut);

    always_comb begin
        state_d     = state_q;
        valid_d     = valid_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        err_d       = err_q | (bus.rtn_valid & (outstanding_q == '0));
        rtn_cnt_d   = rtn_cnt_q;
        if (rtn_ok && (rtn_cnt_q != '1)) begin
            rtn_cnt_d = rtn_cnt_q + CNT_W'(1);
        end
`ifdef MCASH_REQ_DRV_RAND_GAP_EN
        gap_d = gap_q;
`endif

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    rtn_cnt_d   = '0;
                    addr_d      = base_addr_i;
                    remaining_d = num_req_i;
`ifdef MCASH_REQ_DRV_RAND_GAP_EN
                    gap_d = '0;
`endif
                    if (num_req_i != '0) begin
                        state_d = StIssue;
                        valid_d = credit;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StIssue: begin
                if (kickoff) begin
                    addr_d      = addr_q + Stride;
                    remaining_d = remaining_q - CNT_W'(1);
                    if (remaining_q == CNT_W'(1)) begin
                        state_d = StDrain;
                        valid_d = 1'b0;
                    end else begin
`ifdef MCASH_REQ_DRV_RAND_GAP_EN
                        gap_d   = lfsr_q[1:0];
                        valid_d = (lfsr_q[1:0] == 2'd0) & credit;
`else
                        valid_d = credit;
`endif
                    end
                end else if (!valid_q) begin
`ifdef MCASH_REQ_DRV_RAND_GAP_EN
                    if (gap_q != 2'd0) begin
                        gap_d   = gap_q - 2'd1;
                        valid_d = (gap_q == 2'd1) & credit;
                    end else begin
                        valid_d = credit;
                    end
`else
                    valid_d = credit;
`endif
                end
            end
            StDrain: begin
                if (outstanding_d == '0) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= StIdle;
            valid_q       <= 1'b0;
            addr_q        <= '0;
            remaining_q   <= '0;
            outstanding_q <= '0;
            rtn_cnt_q     <= '0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            valid_q       <= valid_d;
            addr_q        <= addr_d;
            remaining_q   <= remaining_d;
            outstanding_q <= outstanding_d;
            rtn_cnt_q     <= rtn_cnt_d;
            err_q         <= err_d;
        end
    end

`ifdef MCASH_REQ_DRV_RAND_GAP_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lfsr_q <= 16'hACE1;
            gap_q  <= '0;
        end else begin
            lfsr_q <= lfsr_d;
            gap_q  <= gap_d;
        end
    end
`endif

    assign bus.req_valid = valid_q;
    assign bus.req_addr  = addr_q;
    assign outstanding_o = outstanding_q;
    assign rtn_cnt_o     = rtn_cnt_q;
    assign busy_o        = (state_q != StIdle);
    assign done_o        = (state_q == StDone);
    assign err_o         = err_q;

endmodule

// File: tb/tb_mcash_ch_req_driver.sv
// Directed self-checking bench for mcash_ch_req_driver (default build, no random gaps).
module tb_mcash_ch_req_driver;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] base_addr;
    logic [9:0]  num_req;
    logic [4:0]  outstanding;
    logic [9:0]  rtn_cnt;
    logic        busy;
    logic        done;
    logic        err;

    logic        auto_en;
    logic        man_rtn;
    logic [2:0]  kpipe;

    int checks;
    int failures;

    mcash_ch_req_driver_if #(.ADDR_W(32), .DATA_W(64)) bus ();

    mcash_ch_req_driver #(
        .ADDR_W          (32),
        .DATA_W          (64),
        .CNT_W           (10),
        .MAX_OUTSTANDING (16),
        .ADDR_STRIDE     (64)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .start_i       (start),
        .base_addr_i   (base_addr),
        .num_req_i     (num_req),
        .bus           (bus),
        .outstanding_o (outstanding),
        .rtn_cnt_o     (rtn_cnt),
        .busy_o        (busy),
        .done_o        (done),
        .err_o         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: each accepted request returns three cycles later when enabled.
    always @(posedge clk) begin
        kpipe <= {kpipe[1:0], bus.req_valid & bus.req_allowIn};
    end
    assign bus.rtn_valid = (auto_en & kpipe[2]) | man_rtn;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks          = 0;
        failures        = 0;
        rst             = 1'b1;
        start           = 1'b0;
        base_addr       = '0;
        num_req         = '0;
        auto_en         = 1'b0;
        man_rtn         = 1'b0;
        kpipe           = '0;
        bus.req_allowIn = 1'b0;
        bus.rtn_data    = 64'hDEAD_BEEF_0000_0001;
        tick();
        tick();
        chk("rst_valid", bus.req_valid, 0);
        chk("rst_addr", bus.req_addr, 0);
        chk("rst_outstanding", outstanding, 0);
        chk("rst_rtn_cnt", rtn_cnt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        rst = 1'b0;
        tick();

        // Burst of 4 with auto returns
        auto_en         = 1'b1;
        bus.req_allowIn = 1'b1;
        start           = 1'b1;
        base_addr       = 32'h1000;
        num_req         = 10'd4;
        tick();
        start = 1'b0;
        chk("t1_valid_rise", bus.req_valid, 1);
        chk("t1_addr0", bus.req_addr, 32'h1000);
        chk("t1_busy", busy, 1);
        tick();
        chk("t1_addr1", bus.req_addr, 32'h1040);
        chk("t1_out1", outstanding, 1);
        tick();
        chk("t1_addr2", bus.req_addr, 32'h1080);
        tick();
        chk("t1_addr3", bus.req_addr, 32'h10C0);
        chk("t1_out3", outstanding, 3);
        tick();
        chk("t1_valid_low", bus.req_valid, 0);
        chk("t1_out_kick_rtn", outstanding, 3);
        tick();
        tick();
        chk("t1_out_drain", outstanding, 1);
        chk("t1_no_early_done", done, 0);
        tick();
        chk("t1_done", done, 1);
        chk("t1_out0", outstanding, 0);
        chk("t1_rtn_cnt", rtn_cnt, 4);
        chk("t1_err", err, 0);
        tick();
        chk("t1_done_pulse", done, 0);
        chk("t1_idle", busy, 0);
        auto_en = 1'b0;

        // Hold under allowIn low
        bus.req_allowIn = 1'b0;
        start           = 1'b1;
        base_addr       = 32'h2000;
        num_req         = 10'd2;
        tick();
        start = 1'b0;
        chk("t2_valid", bus.req_valid, 1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t2_hold_valid", bus.req_valid, 1);
            chk("t2_hold_addr", bus.req_addr, 32'h2000);
            chk("t2_hold_out", outstanding, 0);
        end
        bus.req_allowIn = 1'b1;
        tick();
        chk("t2_first_kick", outstanding, 1);
        chk("t2_addr1", bus.req_addr, 32'h2040);
        tick();
        chk("t2_valid_low", bus.req_valid, 0);
        chk("t2_out2", outstanding, 2);
        man_rtn = 1'b1;
        tick();
        tick();
        man_rtn = 1'b0;
        chk("t2_done", done, 1);
        chk("t2_rtn_cnt", rtn_cnt, 2);
        tick();

        // Credit cap at 16 with 20 requests, no returns
        start     = 1'b1;
        base_addr = 32'h0;
        num_req   = 10'd20;
        tick();
        start = 1'b0;
        chk("t3_valid", bus.req_valid, 1);
        repeat (16) tick();
        chk("t3_out16", outstanding, 16);
        chk("t3_valid_low", bus.req_valid, 0);
        chk("t3_addr", bus.req_addr, 32'h400);
        tick();
        chk("t3_stay_low", bus.req_valid, 0);
        man_rtn = 1'b1;
        tick();
        man_rtn = 1'b0;
        chk("t3_out15", outstanding, 15);
        chk("t3_valid_again", bus.req_valid, 1);
        tick();
        chk("t3_17th_kick", outstanding, 16);
        chk("t3_addr17", bus.req_addr, 32'h440);
        chk("t3_valid_low2", bus.req_valid, 0);

        // Simultaneous kickoff and return at outstanding 5
        bus.req_allowIn = 1'b0;
        man_rtn         = 1'b1;
        repeat (11) tick();
        man_rtn = 1'b0;
        chk("t4_out5", outstanding, 5);
        chk("t4_valid", bus.req_valid, 1);
        chk("t4_addr", bus.req_addr, 32'h440);
        bus.req_allowIn = 1'b1;
        man_rtn         = 1'b1;
        tick();
        man_rtn = 1'b0;
        chk("t4_out_same", outstanding, 5);
        chk("t4_addr_next", bus.req_addr, 32'h480);
        tick();
        tick();
        chk("t4_out7", outstanding, 7);
        chk("t4_last_valid_low", bus.req_valid, 0);
        man_rtn = 1'b1;
        repeat (7) tick();
        man_rtn = 1'b0;
        chk("t4_done", done, 1);
        chk("t4_rtn_cnt", rtn_cnt, 20);
        chk("t4_err", err, 0);
        tick();

        // Stray return in IDLE
        man_rtn = 1'b1;
        tick();
        man_rtn = 1'b0;
        chk("t5_err", err, 1);
        chk("t5_out0", outstanding, 0);
        chk("t5_rtn_cnt", rtn_cnt, 20);
        tick();
        tick();
        chk("t5_err_sticky", err, 1);

        // Zero-length burst goes straight to DONE
        start   = 1'b1;
        num_req = 10'd0;
        tick();
        start = 1'b0;
        chk("z_done", done, 1);
        chk("z_valid", bus.req_valid, 0);
        chk("z_rtn_cnt_clr", rtn_cnt, 0);
        tick();
        chk("z_idle", busy, 0);

        // Reset in the middle of ISSUE
        start     = 1'b1;
        base_addr = 32'h3000;
        num_req   = 10'd10;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        chk("t6_out3", outstanding, 3);
        rst = 1'b1;
        #1;
        chk("t6_rst_valid", bus.req_valid, 0);
        chk("t6_rst_addr", bus.req_addr, 0);
        chk("t6_rst_out", outstanding, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_err", err, 0);
        tick();
        rst = 1'b0;
        start     = 1'b1;
        base_addr = 32'h5000;
        num_req   = 10'd1;
        tick();
        start = 1'b0;
        chk("t6_new_valid", bus.req_valid, 1);
        chk("t6_new_addr", bus.req_addr, 32'h5000);
        tick();
        chk("t6_new_out1", outstanding, 1);
        man_rtn = 1'b1;
        tick();
        man_rtn = 1'b0;
        chk("t6_new_done", done, 1);
        chk("t6_new_rtn_cnt", rtn_cnt, 1);
        chk("t6_new_err", err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
